dividend_unit: RTL and testbench
================================

DIVIDEND_UNIT -- requirements
Module: dividend_unit

Interface
REQ-001 The module SHALL have a single clock domain and an asynchronous, active-low reset. The ports SHALL be `clk` (input, 1 bit, rising-edge clock) and `rst_n` (input, 1 bit, async active-low reset).
REQ-002 Port `start` SHALL be input, 1 bit: request a new division; sampled only in IDLE.
REQ-003 Port `dividend` SHALL be input, 16 bits: numerator, captured on an accepted start.
REQ-004 Port `divisor` SHALL be input, 16 bits: denominator, captured on an accepted start.
REQ-005 Port `C` SHALL be input, 1 bit: compare result from subtract_compare_unit (1 = Remainder >= curr_divisor).
REQ-006 Port `curr_remainder` SHALL be input, 17 bits: difference from subtract_compare_unit.
REQ-007 Port `Remainder` SHALL be output, 17 bits: working remainder register, driven to subtract_compare_unit.
REQ-008 Port `curr_divisor` SHALL be output, 16 bits: latched divisor, driven to subtract_compare_unit.
REQ-009 Ports `quotient` and `remainder_out` SHALL each be output, 16 bits: results.
REQ-010 Ports `busy`, `done` and `div_by_zero` SHALL each be output, 1 bit: status signals.

Function
REQ-011 The FSM states SHALL be IDLE, SHIFT, SUB and DONE.
REQ-012 In IDLE with start=1 and divisor!=0, the unit SHALL perform all of the following on that edge: latch the divisor, load Q=dividend, R=0, iteration count=0, clear div_by_zero, and go to SHIFT.
REQ-013 In SHIFT, the unit SHALL shift {R,Q} left by 1 (R<={R[15:0],Q[15]}, Q<={Q[14:0],1'b0}) and go to SUB.
REQ-014 In SUB with C=1, the unit SHALL set R<=curr_remainder and Q[0]<=1. With C=0, R SHALL be unchanged (restore).
REQ-015 In SUB, the iteration count SHALL increment. When count was 15, the FSM SHALL go to DONE; otherwise it SHALL go to SHIFT.
REQ-016 In DONE, the unit SHALL assert done for exactly one cycle and return to IDLE unconditionally.
REQ-017 Latency: for start sampled at edge 0, done SHALL be high in the cycle following edge 32 (16 SHIFT/SUB pairs).
REQ-018 busy SHALL be 1 in SHIFT and SUB, and 0 in IDLE and DONE.
REQ-019 quotient SHALL equal Q[15:0] and remainder_out SHALL equal R[15:0]. Both SHALL be stable from DONE until the next accepted start.
REQ-020 Width rule: R SHALL be 17 bits. The post-shift R SHALL be < 2*divisor, so no overflow occurs. R[16] SHALL be 0 after every SUB.
REQ-021 start SHALL be ignored in SHIFT, SUB and DONE. Dividend and divisor input changes while busy SHALL have no effect.
REQ-022 In IDLE with start=1 and divisor==0, the unit SHALL set Q=16'hFFFF, R={1'b0,dividend}, div_by_zero=1, and go directly to DONE (done one cycle after the start edge).
REQ-023 div_by_zero SHALL hold until the next accepted start.
REQ-024 curr_divisor SHALL hold the latched divisor from the accepted start until the next accepted start.

Reset
REQ-025 On rst_n=0 (asynchronous), the unit SHALL enter IDLE and set R, Q, the count and curr_divisor to 0, and busy, done and div_by_zero to 0.
REQ-026 Reset asserted mid-division SHALL abort the operation immediately. No done pulse SHALL follow reset deassertion.
REQ-027 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-028 A shared package div_pkg SHALL hold DATA_W=16, ITER_N=16, CNT_W=5 and the FSM state enum (IDLE, SHIFT, SUB, DONE).
REQ-029 No sub-module SHALL be used. The FSM, the count and the R/Q registers SHALL live in dividend_unit.
REQ-030 subtract_compare_unit SHALL remain a sibling instance wired at the divider top.

Verification
REQ-031 Reset, then start with dividend=100, divisor=7: the bench SHALL check quotient=14, remainder_out=2, done high in the 33rd cycle after the start edge, and busy low in DONE.
REQ-032 dividend=16'hFFFF, divisor=1: the bench SHALL check quotient=16'hFFFF, remainder_out=0, div_by_zero=0.
REQ-033 dividend=3, divisor=10: the bench SHALL check quotient=0, remainder_out=3, and that C=0 was observed in every SUB.
REQ-034 dividend=5, divisor=0: the bench SHALL check div_by_zero=1, quotient=16'hFFFF, remainder_out=5, and done one cycle after start.
REQ-035 Pulse start again at cycle 10 of a 1000/3 division: the bench SHALL check that the pulse is ignored and the result is quotient=333, remainder_out=1.
REQ-036 Drive rst_n low at cycle 12 of a 1000/3 division: the bench SHALL check all outputs are 0 and the state is IDLE, with no done pulse. It SHALL then run 1000/3 and check quotient=333.

Source files
------------

// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared constants and FSM state type for the restoring divider.
//   DATA_W : operand width (dividend, divisor, quotient, remainder)
//   ITER_N : number of SHIFT/SUB iterations (one per quotient bit)
//   CNT_W  : width of the iteration counter (must hold ITER_N)
// -----------------------------------------------------------------------------
package div_pkg;

  localparam int DATA_W = 16;
  localparam int ITER_N = 16;
  localparam int CNT_W  = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    SUB   = 2'd2,
    DONE  = 2'd3
  } div_state_t;

endpackage : div_pkg

// File: rtl/dividend_unit.sv
// -----------------------------------------------------------------------------
// dividend_unit
// Control and register half of a 16-bit restoring divider. The subtract /
// compare datapath lives in a sibling instance (subtract_compare_unit) that
// sees Remainder and curr_divisor and returns C and curr_remainder.
//
// Each quotient bit takes two cycles: SHIFT moves {R,Q} left by one, SUB
// commits the trial subtraction when C says R >= divisor. A divisor of zero
// skips the loop and reports div_by_zero with saturated quotient.
//
// Ports
//   clk, rst_n      : clock, asynchronous active-low reset
//   start           : request a division (sampled only in IDLE)
//   dividend        : numerator, captured on an accepted start
//   divisor         : denominator, captured on an accepted start
//   C               : 1 when Remainder >= curr_divisor (from sibling)
//   curr_remainder  : Remainder - curr_divisor (from sibling)
//   Remainder       : 17-bit working remainder, to sibling
//   curr_divisor    : latched divisor, to sibling
//   quotient        : result quotient
//   remainder_out   : result remainder
//   busy            : high while iterating (SHIFT/SUB)
//   done            : one-cycle pulse when the result is ready
//   div_by_zero     : set when the accepted divisor was zero
// -----------------------------------------------------------------------------
module dividend_unit
  import div_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  input  logic              C,
  input  logic [DATA_W:0]   curr_remainder,
  output logic [DATA_W:0]   Remainder,
  output logic [DATA_W-1:0] curr_divisor,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder_out,
  output logic              busy,
  output logic              done,
  output logic              div_by_zero
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER_N - 1);

  div_state_t        state, state_nxt;
  logic [DATA_W:0]   r_q;
  logic [DATA_W-1:0] q_q;
  logic [DATA_W-1:0] div_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              dbz_q;

  logic divisor_zero;
  assign divisor_zero = (divisor == '0);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment first means every path assigns state_nxt,
  // so no latch is inferred when a case arm leaves it alone.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = divisor_zero ? DONE : SHIFT;
        end
      end
      SHIFT: state_nxt = SUB;
      SUB:   state_nxt = (cnt_q == LAST_ITER) ? DONE : SHIFT;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers: remainder, quotient, divisor latch, count, flag.
  // Outside the start edge and the iteration states everything holds, which
  // keeps the results stable from DONE until the next accepted start.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= '0;
      q_q   <= '0;
      div_q <= '0;
      cnt_q <= '0;
      dbz_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            cnt_q <= '0;
            div_q <= divisor;
            if (divisor_zero) begin
              q_q   <= '1;
              r_q   <= {1'b0, dividend};
              dbz_q <= 1'b1;
            end else begin
              q_q   <= dividend;
              r_q   <= '0;
              dbz_q <= 1'b0;
            end
          end
        end
        SHIFT: begin
          // R stays below 2*divisor after the shift, so 17 bits never overflow.
          r_q <= {r_q[DATA_W-1:0], q_q[DATA_W-1]};
          q_q <= {q_q[DATA_W-2:0], 1'b0};
        end
        SUB: begin
          // C=0 is the restore case: R is simply left as shifted.
          if (C) begin
            r_q    <= curr_remainder;
            q_q[0] <= 1'b1;
          end
          cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign Remainder     = r_q;
  assign curr_divisor  = div_q;
  assign quotient      = q_q;
  assign remainder_out = r_q[DATA_W-1:0];
  assign busy          = (state == SHIFT) || (state == SUB);
  assign done          = (state == DONE);
  assign div_by_zero   = dbz_q;

endmodule : dividend_unit

// File: tb/tb_dividend_unit.sv
// -----------------------------------------------------------------------------
// tb_dividend_unit
// Directed bench for dividend_unit. A behavioural stand-in for the sibling
// subtract_compare_unit closes the loop; expected results are hand-computed.
// -----------------------------------------------------------------------------
module tb_dividend_unit;
  import div_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        c;
  logic [16:0] curr_remainder;
  logic [16:0] remainder_w;
  logic [15:0] curr_divisor;
  logic [15:0] quotient;
  logic [15:0] remainder_out;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int pass_cnt  = 0;
  int check_cnt = 0;

  dividend_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .dividend       (dividend),
    .divisor        (divisor),
    .C              (c),
    .curr_remainder (curr_remainder),
    .Remainder      (remainder_w),
    .curr_divisor   (curr_divisor),
    .quotient       (quotient),
    .remainder_out  (remainder_out),
    .busy           (busy),
    .done           (done),
    .div_by_zero    (div_by_zero)
  );

  // Stand-in for subtract_compare_unit.
  assign c              = (remainder_w >= {1'b0, curr_divisor});
  assign curr_remainder = remainder_w - {1'b0, curr_divisor};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Called at a negedge. Issues start, then watches up to 40 cycles.
  // Cycle 1 is the cycle following the start edge. glitch_at != 0 pulses
  // start (with changed operands) at that cycle.
  task automatic run_div(input logic [15:0] dvd, input logic [15:0] dvs,
                         input int glitch_at,
                         output int done_cyc, output int done_len,
                         output bit saw_c1, output bit busy_at_done);
    done_cyc     = -1;
    done_len     = 0;
    saw_c1       = 1'b0;
    busy_at_done = 1'b1;
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (cyc == glitch_at) begin
        start    = 1'b1;
        dividend = 16'h1234;
        divisor  = 16'h0005;
      end else if (cyc == glitch_at + 1) begin
        start = 1'b0;
      end
      if (dut.state == SUB && c) saw_c1 = 1'b1;
      if (done) begin
        done_len++;
        if (done_cyc < 0) begin
          done_cyc     = cyc;
          busy_at_done = busy;
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  int done_cyc, done_len;
  bit saw_c1, busy_at_done;
  int done_seen;

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = 16'd0;
    divisor  = 16'd0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder_w), 32'd0);
    check("rst_curr_div", 32'(curr_divisor), 32'd0);
    check("rst_status", {29'd0, busy, done, div_by_zero}, 32'd0);
    check("rst_cnt", 32'(dut.cnt_q), 32'd0);

    // 100 / 7, start on the first edge after reset release
    rst_n = 1'b1;
    run_div(16'd100, 16'd7, 0, done_cyc, done_len, saw_c1, busy_at_done);
    check("d100_q", 32'(quotient), 32'd14);
    check("d100_r", 32'(remainder_out), 32'd2);
    check("d100_done_cyc", done_cyc, 32'd33);
    check("d100_done_len", done_len, 32'd1);
    check("d100_busy_in_done", 32'(busy_at_done), 32'd0);
    check("d100_curr_div", 32'(curr_divisor), 32'd7);
    check("d100_r16", 32'(remainder_w[16]), 32'd0);

    // FFFF / 1
    run_div(16'hFFFF, 16'd1, 0, done_cyc, done_len, saw_c1, busy_at_done);
    check("dffff_q", 32'(quotient), 32'h0000FFFF);
    check("dffff_r", 32'(remainder_out), 32'd0);
    check("dffff_dbz", 32'(div_by_zero), 32'd0);
    check("dffff_done_cyc", done_cyc, 32'd33);

    // 3 / 10: every trial subtraction fails
    run_div(16'd3, 16'd10, 0, done_cyc, done_len, saw_c1, busy_at_done);
    check("d3_q", 32'(quotient), 32'd0);
    check("d3_r", 32'(remainder_out), 32'd3);
    check("d3_no_c1", 32'(saw_c1), 32'd0);

    // 5 / 0
    run_div(16'd5, 16'd0, 0, done_cyc, done_len, saw_c1, busy_at_done);
    check("dz_dbz", 32'(div_by_zero), 32'd1);
    check("dz_q", 32'(quotient), 32'h0000FFFF);
    check("dz_r", 32'(remainder_out), 32'd5);
    check("dz_done_cyc", done_cyc, 32'd1);
    check("dz_done_len", done_len, 32'd1);

    // 1000 / 3 with a start pulse and operand change at cycle 10
    run_div(16'd1000, 16'd3, 10, done_cyc, done_len, saw_c1, busy_at_done);
    check("glitch_q", 32'(quotient), 32'd333);
    check("glitch_r", 32'(remainder_out), 32'd1);
    check("glitch_done_cyc", done_cyc, 32'd33);
    check("glitch_dbz_clr", 32'(div_by_zero), 32'd0);
    check("glitch_curr_div", 32'(curr_divisor), 32'd3);

    // 1000 / 3 aborted by reset at cycle 12
    dividend = 16'd1000;
    divisor  = 16'd3;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    check("abort_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_state", 32'(dut.state), 32'(IDLE));
    check("abort_q", 32'(quotient), 32'd0);
    check("abort_r", 32'(remainder_w), 32'd0);
    check("abort_curr_div", 32'(curr_divisor), 32'd0);
    check("abort_status", {29'd0, busy, done, div_by_zero}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("abort_no_done", done_seen, 32'd0);

    run_div(16'd1000, 16'd3, 0, done_cyc, done_len, saw_c1, busy_at_done);
    check("after_abort_q", 32'(quotient), 32'd333);
    check("after_abort_r", 32'(remainder_out), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule : tb_dividend_unit
